// File: rtl/dma_reg_frontend_pkg.sv
// Shared types and constants for the DMA register frontend: register map,
// response codes, descriptor layout and FSM state encodings.
package dma_reg_frontend_pkg;

  localparam int unsigned DMA_ADDR_W = 64;
  localparam int unsigned DMA_ID_W   = 32;

  localparam logic [11:0] OFS_SRC       = 12'h000;
  localparam logic [11:0] OFS_DST       = 12'h008;
  localparam logic [11:0] OFS_NUM_BYTES = 12'h010;
  localparam logic [11:0] OFS_CONF      = 12'h018;
  localparam logic [11:0] OFS_STATUS    = 12'h020;
  localparam logic [11:0] OFS_NEXT_ID   = 12'h028;
  localparam logic [11:0] OFS_DONE      = 12'h030;

  localparam int unsigned CONF_DECOUPLE  = 0;
  localparam int unsigned CONF_DEBURST   = 1;
  localparam int unsigned CONF_SERIALIZE = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_ADDR_W-1:0] num_bytes;
    logic                  decouple;
    logic                  deburst;
    logic                  serialize;
    logic [DMA_ID_W-1:0]   id;
  } burst_req_t;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LAUNCH, R_RESP} rd_state_e;

  function automatic logic [63:0] apply_strb(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_reg_frontend_wr_join.sv
// Write-channel joiner: accepts AW and W independently and presents one
// combined address/data/strobe beat, then holds B until it is taken.
//
//  state     | meaning
//  W_IDLE    | nothing held, both AW and W may be accepted
//  W_HAVE_AW | address held, waiting for write data
//  W_HAVE_W  | data held, waiting for write address
//  W_RESP    | register updated, B valid until b_ready
module dma_reg_frontend_wr_join
  import dma_reg_frontend_pkg::*;
#(
  parameter int unsigned RegAddrWidth = 12,
  parameter int unsigned DataWidth    = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_aw_valid,
  output logic                    o_aw_ready,
  input  logic [RegAddrWidth-1:0] i_aw_addr,
  input  logic                    i_w_valid,
  output logic                    o_w_ready,
  input  logic [DataWidth-1:0]    i_w_data,
  input  logic [DataWidth/8-1:0]  i_w_strb,
  output logic                    o_b_valid,
  input  logic                    i_b_ready,
  output logic                    o_join_valid,
  output logic [RegAddrWidth-1:0] o_join_addr,
  output logic [DataWidth-1:0]    o_join_data,
  output logic [DataWidth/8-1:0]  o_join_strb
);

  wr_state_e                r_state;
  wr_state_e                w_state_nxt;
  logic [RegAddrWidth-1:0]  r_aw_addr;
  logic [DataWidth-1:0]     r_w_data;
  logic [DataWidth/8-1:0]   r_w_strb;
  logic                     w_cap_aw;
  logic                     w_cap_w;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= W_IDLE;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap_aw) r_aw_addr <= i_aw_addr;
      if (w_cap_w) begin
        r_w_data <= i_w_data;
        r_w_strb <= i_w_strb;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_aw_ready   = 1'b0;
    o_w_ready    = 1'b0;
    o_b_valid    = 1'b0;
    o_join_valid = 1'b0;
    o_join_addr  = r_aw_addr;
    o_join_data  = r_w_data;
    o_join_strb  = r_w_strb;
    w_cap_aw     = 1'b0;
    w_cap_w      = 1'b0;
    case (r_state)
      W_IDLE: begin
        o_aw_ready = i_en;
        o_w_ready  = i_en;
        if (i_en && i_aw_valid && i_w_valid) begin
          o_join_valid = 1'b1;
          o_join_addr  = i_aw_addr;
          o_join_data  = i_w_data;
          o_join_strb  = i_w_strb;
          w_state_nxt  = W_RESP;
        end else if (i_en && i_aw_valid) begin
          w_cap_aw    = 1'b1;
          w_state_nxt = W_HAVE_AW;
        end else if (i_en && i_w_valid) begin
          w_cap_w     = 1'b1;
          w_state_nxt = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          o_join_valid = 1'b1;
          o_join_data  = i_w_data;
          o_join_strb  = i_w_strb;
          w_state_nxt  = W_RESP;
        end
      end
      W_HAVE_W: begin
        o_aw_ready = 1'b1;
        if (i_aw_valid) begin
          o_join_valid = 1'b1;
          o_join_addr  = i_aw_addr;
          w_state_nxt  = W_RESP;
        end
      end
      W_RESP: begin
        o_b_valid = 1'b1;
        if (i_b_ready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: rtl/dma_reg_frontend.sv
// DMA configuration frontend: AXI-Lite register file, NEXT_ID-triggered
// descriptor launch to the backend, and completion accounting.
//
//  state    | meaning
//  R_IDLE   | ready for a read address
//  R_LAUNCH | descriptor offered to backend, read response waits
//  R_RESP   | read data valid until r_ready
module dma_reg_frontend
  import dma_reg_frontend_pkg::*;
#(
  parameter int unsigned AddrWidth    = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned RegAddrWidth = 12,
  parameter int unsigned IdCntWidth   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [RegAddrWidth-1:0] aw_addr_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DataWidth-1:0]    w_data_i,
  input  logic [DataWidth/8-1:0]  w_strb_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [1:0]              b_resp_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [RegAddrWidth-1:0] ar_addr_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DataWidth-1:0]    r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    burst_valid_o,
  input  logic                    burst_ready_i,
  output logic [AddrWidth-1:0]    burst_src_o,
  output logic [AddrWidth-1:0]    burst_dst_o,
  output logic [AddrWidth-1:0]    burst_num_bytes_o,
  output logic                    burst_decouple_o,
  output logic                    burst_deburst_o,
  output logic                    burst_serialize_o,
  output logic [IdCntWidth-1:0]   burst_id_o,
  input  logic                    done_i,
  output logic                    busy_o
);

  logic                    r_out_en;
  logic [AddrWidth-1:0]    r_src;
  logic [AddrWidth-1:0]    r_dst;
  logic [AddrWidth-1:0]    r_num_bytes;
  logic [2:0]              r_conf;
  logic [IdCntWidth-1:0]   r_issued;
  logic [IdCntWidth-1:0]   r_done;
  logic [1:0]              r_b_resp;
  logic [DataWidth-1:0]    r_rdata;
  logic [1:0]              r_rresp;
  burst_req_t              r_desc;
  rd_state_e               r_rd_state;
  rd_state_e               w_rd_state_nxt;

  logic                    w_join_valid;
  logic [RegAddrWidth-1:0] w_join_addr;
  logic [DataWidth-1:0]    w_join_data;
  logic [DataWidth/8-1:0]  w_join_strb;
  logic                    w_wr_ok;
  logic [63:0]             w_wr_old;
  logic [63:0]             w_wr_merged;
  logic                    w_ar_hs;
  logic                    w_ar_err;
  logic                    w_ar_next_id;
  logic                    w_zero_len;
  logic                    w_zl_launch;
  logic [IdCntWidth-1:0]   w_next_id;
  logic [DataWidth-1:0]    w_rd_mux;

  // Readies stay low until the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_out_en <= 1'b0;
    else         r_out_en <= 1'b1;
  end

  dma_reg_frontend_wr_join #(
    .RegAddrWidth(RegAddrWidth),
    .DataWidth   (DataWidth)
  ) u_wr_join (
    .i_clk       (clk_i),
    .i_rst_n     (rst_ni),
    .i_en        (r_out_en),
    .i_aw_valid  (aw_valid_i),
    .o_aw_ready  (aw_ready_o),
    .i_aw_addr   (aw_addr_i),
    .i_w_valid   (w_valid_i),
    .o_w_ready   (w_ready_o),
    .i_w_data    (w_data_i),
    .i_w_strb    (w_strb_i),
    .o_b_valid   (b_valid_o),
    .i_b_ready   (b_ready_i),
    .o_join_valid(w_join_valid),
    .o_join_addr (w_join_addr),
    .o_join_data (w_join_data),
    .o_join_strb (w_join_strb)
  );

  // Only the four RW registers accept writes; everything else is SLVERR.
  assign w_wr_ok = (w_join_addr == RegAddrWidth'(OFS_SRC))       ||
                   (w_join_addr == RegAddrWidth'(OFS_DST))       ||
                   (w_join_addr == RegAddrWidth'(OFS_NUM_BYTES)) ||
                   (w_join_addr == RegAddrWidth'(OFS_CONF));

  always_comb begin
    w_wr_old = '0;
    case (w_join_addr)
      RegAddrWidth'(OFS_SRC):       w_wr_old = 64'(r_src);
      RegAddrWidth'(OFS_DST):       w_wr_old = 64'(r_dst);
      RegAddrWidth'(OFS_NUM_BYTES): w_wr_old = 64'(r_num_bytes);
      RegAddrWidth'(OFS_CONF):      w_wr_old = {61'b0, r_conf};
      default:                      w_wr_old = '0;
    endcase
  end

  assign w_wr_merged = apply_strb(w_wr_old, w_join_data, w_join_strb);

  assign w_ar_hs      = ar_valid_i && r_out_en && (r_rd_state == R_IDLE);
  assign w_ar_err     = (ar_addr_i[2:0] != 3'b000) || (ar_addr_i > RegAddrWidth'(OFS_DONE));
  assign w_ar_next_id = (ar_addr_i == RegAddrWidth'(OFS_NEXT_ID));
  assign w_zero_len   = (r_num_bytes == '0);
  assign w_zl_launch  = w_ar_hs && !w_ar_err && w_ar_next_id && w_zero_len;
  assign w_next_id    = r_issued + IdCntWidth'(1);

  always_comb begin
    w_rd_mux = '0;
    case (ar_addr_i)
      RegAddrWidth'(OFS_SRC):       w_rd_mux = DataWidth'(r_src);
      RegAddrWidth'(OFS_DST):       w_rd_mux = DataWidth'(r_dst);
      RegAddrWidth'(OFS_NUM_BYTES): w_rd_mux = DataWidth'(r_num_bytes);
      RegAddrWidth'(OFS_CONF):      w_rd_mux = DataWidth'(r_conf);
      RegAddrWidth'(OFS_STATUS):    w_rd_mux = DataWidth'(busy_o);
      RegAddrWidth'(OFS_DONE):      w_rd_mux = DataWidth'(r_done);
      default:                      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rd_state <= R_IDLE;
    else         r_rd_state <= w_rd_state_nxt;
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    ar_ready_o     = 1'b0;
    r_valid_o      = 1'b0;
    burst_valid_o  = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        ar_ready_o = r_out_en;
        if (w_ar_hs) begin
          if (!w_ar_err && w_ar_next_id && !w_zero_len) w_rd_state_nxt = R_LAUNCH;
          else                                          w_rd_state_nxt = R_RESP;
        end
      end
      R_LAUNCH: begin
        burst_valid_o = 1'b1;
        if (burst_ready_i) w_rd_state_nxt = R_RESP;
      end
      R_RESP: begin
        r_valid_o = 1'b1;
        if (r_ready_i) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_num_bytes <= '0;
      r_conf      <= '0;
      r_b_resp    <= RESP_OKAY;
    end else if (w_join_valid) begin
      r_b_resp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      case (w_join_addr)
        RegAddrWidth'(OFS_SRC):       r_src       <= AddrWidth'(w_wr_merged);
        RegAddrWidth'(OFS_DST):       r_dst       <= AddrWidth'(w_wr_merged);
        RegAddrWidth'(OFS_NUM_BYTES): r_num_bytes <= AddrWidth'(w_wr_merged);
        RegAddrWidth'(OFS_CONF):      r_conf      <= w_wr_merged[2:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issued <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_desc   <= '0;
    end else if (w_ar_hs) begin
      if (w_ar_err) begin
        r_rdata <= '0;
        r_rresp <= RESP_SLVERR;
      end else if (w_ar_next_id) begin
        r_rresp          <= RESP_OKAY;
        r_desc.src       <= DMA_ADDR_W'(r_src);
        r_desc.dst       <= DMA_ADDR_W'(r_dst);
        r_desc.num_bytes <= DMA_ADDR_W'(r_num_bytes);
        r_desc.decouple  <= r_conf[CONF_DECOUPLE];
        r_desc.deburst   <= r_conf[CONF_DEBURST];
        r_desc.serialize <= r_conf[CONF_SERIALIZE];
        r_desc.id        <= DMA_ID_W'(w_next_id);
        if (w_zero_len) begin
          r_issued <= w_next_id;
          r_rdata  <= DataWidth'(w_next_id);
        end
      end else begin
        r_rdata <= w_rd_mux;
        r_rresp <= RESP_OKAY;
      end
    end else if ((r_rd_state == R_LAUNCH) && burst_ready_i) begin
      r_issued <= IdCntWidth'(r_desc.id);
      r_rdata  <= DataWidth'(r_desc.id);
    end
  end

  // A zero-length launch counts as issued and completed in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_done <= '0;
    else         r_done <= r_done + IdCntWidth'(done_i) + IdCntWidth'(w_zl_launch);
  end

  assign busy_o            = (r_issued != r_done) | burst_valid_o;
  assign b_resp_o          = r_b_resp;
  assign r_data_o          = r_rdata;
  assign r_resp_o          = r_rresp;
  assign burst_src_o       = AddrWidth'(r_desc.src);
  assign burst_dst_o       = AddrWidth'(r_desc.dst);
  assign burst_num_bytes_o = AddrWidth'(r_desc.num_bytes);
  assign burst_decouple_o  = r_desc.decouple;
  assign burst_deburst_o   = r_desc.deburst;
  assign burst_serialize_o = r_desc.serialize;
  assign burst_id_o        = IdCntWidth'(r_desc.id);

endmodule

// File: tb/tb_dma_reg_frontend.sv
// Directed self-checking bench for dma_reg_frontend.
module tb_dma_reg_frontend;

  logic        clk, rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [11:0] aw_addr, ar_addr;
  logic [63:0] w_data, r_data;
  logic [7:0]  w_strb;
  logic [1:0]  b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic        burst_valid, burst_ready;
  logic [63:0] burst_src, burst_dst, burst_num_bytes;
  logic        burst_decouple, burst_deburst, burst_serialize;
  logic [31:0] burst_id;
  logic        done_i, busy;

  int n_pass = 0;
  int n_total = 0;

  dma_reg_frontend dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_resp_o(r_resp),
    .burst_valid_o(burst_valid), .burst_ready_i(burst_ready),
    .burst_src_o(burst_src), .burst_dst_o(burst_dst), .burst_num_bytes_o(burst_num_bytes),
    .burst_decouple_o(burst_decouple), .burst_deburst_o(burst_deburst),
    .burst_serialize_o(burst_serialize), .burst_id_o(burst_id),
    .done_i(done_i), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0; w_done = 0; c = 0; resp = 2'bxx;
    @(negedge clk);
    while (!(aw_done && w_done) && c < 200) begin
      aw_valid = !aw_done && (c >= aw_dly); aw_addr = a;
      w_valid  = !w_done && (c >= w_dly);   w_data = d; w_strb = s;
      #1;
      aw_hs = aw_valid && aw_ready;
      w_hs  = w_valid && w_ready;
      @(posedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
      @(negedge clk);
    end
    aw_valid = 0; w_valid = 0; b_ready = 1;
    c = 0;
    while (!b_valid && c < 200) begin @(negedge clk); c++; end
    resp = b_resp;
    if (c >= 200 || !(aw_done && w_done)) begin
      n_total++;
      $display("FAIL write_timeout: addr %h got no response, required one", a);
    end
    @(posedge clk); #1 b_ready = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [63:0] d, output logic [1:0] resp,
                          output int lat);
    int c;
    @(negedge clk);
    ar_valid = 1; ar_addr = a; c = 0;
    #1;
    while (!ar_ready && c < 200) begin @(negedge clk); #1; c++; end
    @(posedge clk);
    @(negedge clk);
    ar_valid = 0; r_ready = 1;
    lat = 0;
    while (!r_valid && lat < 300) begin @(negedge clk); lat++; end
    d = r_data; resp = r_resp;
    if (c >= 200 || lat >= 300) begin
      n_total++;
      $display("FAIL read_timeout: addr %h got no response, required one", a);
    end
    @(posedge clk); #1 r_ready = 0;
  endtask

  task automatic pulse_done();
    @(negedge clk); done_i = 1;
    @(negedge clk); done_i = 0;
  endtask

  task automatic test_reset();
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
    aw_addr = 0; ar_addr = 0; w_data = 0; w_strb = 0;
    burst_ready = 1; done_i = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    n_total++; if ({aw_ready, w_ready, ar_ready} !== 3'b000) $display("FAIL reset_readies: got %b required 000", {aw_ready, w_ready, ar_ready}); else n_pass++;
    n_total++; if ({b_valid, r_valid, burst_valid, busy} !== 4'b0000) $display("FAIL reset_valids: got %b required 0000", {b_valid, r_valid, burst_valid, busy}); else n_pass++;
    n_total++; if ({b_resp, r_resp} !== 4'b0000) $display("FAIL reset_resp: got %b required 0000", {b_resp, r_resp}); else n_pass++;
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rw_regs();
    logic [1:0] rs; logic [63:0] d; int lat;
    axi_write(12'h000, 64'h0000_0000_8000_1000, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b00) $display("FAIL wr_src_resp: got %b required 00", rs); else n_pass++;
    axi_write(12'h008, 64'h0000_0000_8000_2000, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b00) $display("FAIL wr_dst_resp: got %b required 00", rs); else n_pass++;
    axi_write(12'h010, 64'h40, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b00) $display("FAIL wr_num_resp: got %b required 00", rs); else n_pass++;
    axi_write(12'h018, 64'hFFFF_FFFF_FFFF_FFF5, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b00) $display("FAIL wr_conf_resp: got %b required 00", rs); else n_pass++;
    axi_read(12'h000, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'h0000_0000_8000_1000}) $display("FAIL rd_src: got %b/%h required 00/%h", rs, d, 64'h80001000); else n_pass++;
    n_total++; if (lat !== 0) $display("FAIL rd_latency: got %0d required 0", lat); else n_pass++;
    axi_read(12'h008, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'h0000_0000_8000_2000}) $display("FAIL rd_dst: got %b/%h required 00/%h", rs, d, 64'h80002000); else n_pass++;
    axi_read(12'h010, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'h40}) $display("FAIL rd_num: got %b/%h required 00/40", rs, d); else n_pass++;
    axi_read(12'h018, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'h5}) $display("FAIL rd_conf: got %b/%h required 00/5", rs, d); else n_pass++;
    axi_read(12'h030, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'h0}) $display("FAIL rd_done_init: got %b/%h required 00/0", rs, d); else n_pass++;
  endtask

  task automatic test_launch_stall();
    logic [1:0] rs, rs2; logic [63:0] d; int lat, c, cnt; bit stable, rv_after;
    burst_ready = 0; stable = 1; cnt = 0; rv_after = 0;
    fork
      axi_read(12'h028, d, rs, lat);
      begin
        c = 0;
        @(negedge clk);
        while (!burst_valid && c < 50) begin @(negedge clk); c++; end
        while (burst_valid && cnt < 40) begin
          cnt++;
          if (burst_src !== 64'h8000_1000 || burst_dst !== 64'h8000_2000 || burst_num_bytes !== 64'h40 ||
              {burst_decouple, burst_deburst, burst_serialize} !== 3'b101 || burst_id !== 32'd1) stable = 0;
          if (cnt == 11) burst_ready = 1;
          @(negedge clk);
        end
        rv_after = r_valid;
      end
      begin
        repeat (4) @(negedge clk);
        axi_write(12'h000, 64'hDEAD, 8'hFF, 0, 0, rs2);
      end
    join
    burst_ready = 1;
    n_total++; if (cnt !== 11) $display("FAIL burst_valid_cycles: got %0d required 11", cnt); else n_pass++;
    n_total++; if (stable !== 1'b1) $display("FAIL burst_fields_stable: got %b required 1", stable); else n_pass++;
    n_total++; if (rv_after !== 1'b1) $display("FAIL r_valid_after_hs: got %b required 1", rv_after); else n_pass++;
    n_total++; if ({rs, d} !== {2'b00, 64'd1}) $display("FAIL next_id_1: got %b/%h required 00/1", rs, d); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL busy_outstanding: got %b required 1", busy); else n_pass++;
    axi_read(12'h000, d, rs, lat);
    n_total++; if (d !== 64'hDEAD) $display("FAIL src_written_in_launch: got %h required dead", d); else n_pass++;
    pulse_done();
    axi_read(12'h030, d, rs, lat);
    n_total++; if (d !== 64'd1) $display("FAIL done_after_first: got %h required 1", d); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_cleared: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_completion();
    logic [1:0] rs; logic [63:0] d; int lat;
    axi_read(12'h028, d, rs, lat);
    n_total++; if ({d, lat} !== {64'd2, 32'd1}) $display("FAIL next_id_2: got %h lat %0d required 2 lat 1", d, lat); else n_pass++;
    axi_read(12'h028, d, rs, lat);
    n_total++; if (d !== 64'd3) $display("FAIL next_id_3: got %h required 3", d); else n_pass++;
    pulse_done();
    axi_read(12'h030, d, rs, lat);
    n_total++; if (d !== 64'd2) $display("FAIL done_2: got %h required 2", d); else n_pass++;
    axi_read(12'h020, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'd1}) $display("FAIL status_busy: got %b/%h required 00/1", rs, d); else n_pass++;
    pulse_done();
    axi_read(12'h030, d, rs, lat);
    n_total++; if (d !== 64'd3) $display("FAIL done_3: got %h required 3", d); else n_pass++;
    axi_read(12'h020, d, rs, lat);
    n_total++; if (d !== 64'd0) $display("FAIL status_idle: got %h required 0", d); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_idle: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_strb_order();
    logic [1:0] rs; logic [63:0] d; int lat;
    axi_write(12'h000, 64'h0, 8'hFF, 0, 0, rs);
    axi_write(12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 3, 0, rs);
    n_total++; if (rs !== 2'b00) $display("FAIL w_first_resp: got %b required 00", rs); else n_pass++;
    axi_read(12'h000, d, rs, lat);
    n_total++; if (d !== 64'h0000_0000_FFFF_FFFF) $display("FAIL src_strb: got %h required 00000000ffffffff", d); else n_pass++;
    axi_write(12'h008, 64'h1122_3344_5566_7788, 8'hF0, 0, 2, rs);
    axi_read(12'h008, d, rs, lat);
    n_total++; if (d !== 64'h1122_3344_8000_2000) $display("FAIL dst_strb_aw_first: got %h required 1122334480002000", d); else n_pass++;
  endtask

  task automatic test_errors();
    logic [1:0] rs; logic [63:0] d; int lat;
    axi_read(12'h004, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b10, 64'h0}) $display("FAIL rd_misaligned: got %b/%h required 10/0", rs, d); else n_pass++;
    axi_read(12'h038, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b10, 64'h0}) $display("FAIL rd_out_of_range: got %b/%h required 10/0", rs, d); else n_pass++;
    axi_write(12'h028, 64'h77, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b10) $display("FAIL wr_next_id: got %b required 10", rs); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL wr_next_id_no_launch: got busy %b required 0", busy); else n_pass++;
    axi_write(12'h004, 64'h1234_5678, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b10) $display("FAIL wr_misaligned: got %b required 10", rs); else n_pass++;
    axi_write(12'h020, 64'h1, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b10) $display("FAIL wr_status: got %b required 10", rs); else n_pass++;
    axi_write(12'h038, 64'h1, 8'hFF, 0, 0, rs);
    n_total++; if (rs !== 2'b10) $display("FAIL wr_out_of_range: got %b required 10", rs); else n_pass++;
    axi_read(12'h000, d, rs, lat);
    n_total++; if (d !== 64'h0000_0000_FFFF_FFFF) $display("FAIL src_unchanged: got %h required 00000000ffffffff", d); else n_pass++;
    axi_read(12'h030, d, rs, lat);
    n_total++; if ({rs, d} !== {2'b00, 64'd3}) $display("FAIL done_unchanged: got %b/%h required 00/3", rs, d); else n_pass++;
  endtask

  task automatic test_zero_len();
    logic [1:0] rs; logic [63:0] d; int lat; bit seen_bad, fired;
    axi_write(12'h010, 64'h0, 8'hFF, 0, 0, rs);
    seen_bad = 0;
    fork
      axi_read(12'h028, d, rs, lat);
      repeat (8) begin @(negedge clk); if (burst_valid || busy) seen_bad = 1; end
    join
    n_total++; if (seen_bad !== 1'b0) $display("FAIL zl_no_burst: got burst/busy activity %b required 0", seen_bad); else n_pass++;
    n_total++; if ({d, lat} !== {64'd4, 32'd0}) $display("FAIL zl_id: got %h lat %0d required 4 lat 0", d, lat); else n_pass++;
    axi_read(12'h030, d, rs, lat);
    n_total++; if (d !== 64'd4) $display("FAIL zl_done: got %h required 4", d); else n_pass++;
    axi_write(12'h010, 64'h10, 8'hFF, 0, 0, rs);
    axi_read(12'h028, d, rs, lat);
    n_total++; if (d !== 64'd5) $display("FAIL next_id_5: got %h required 5", d); else n_pass++;
    axi_write(12'h010, 64'h0, 8'hFF, 0, 0, rs);
    fired = 0;
    fork
      axi_read(12'h028, d, rs, lat);
      for (int i = 0; i < 20 && !fired; i++) begin
        @(negedge clk); #2;
        if (ar_valid && ar_ready) begin
          done_i = 1; fired = 1;
          @(posedge clk); #1 done_i = 0;
        end
      end
    join
    n_total++; if ({fired, d} !== {1'b1, 64'd6}) $display("FAIL zl_coincident_id: got %b/%h required 1/6", fired, d); else n_pass++;
    axi_read(12'h030, d, rs, lat);
    n_total++; if (d !== 64'd6) $display("FAIL zl_coincident_done: got %h required 6", d); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL zl_coincident_busy: got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_launch();
    logic [1:0] rs; logic [63:0] d; int lat, c;
    axi_write(12'h010, 64'h40, 8'hFF, 0, 0, rs);
    burst_ready = 0;
    @(negedge clk); ar_valid = 1; ar_addr = 12'h028; c = 0;
    #1;
    while (!ar_ready && c < 50) begin @(negedge clk); #1; c++; end
    @(posedge clk); @(negedge clk); ar_valid = 0;
    repeat (2) @(negedge clk);
    n_total++; if (burst_valid !== 1'b1) $display("FAIL launch_pending: got %b required 1", burst_valid); else n_pass++;
    #2 rst_n = 0;
    #1;
    n_total++; if ({burst_valid, busy, ar_ready} !== 3'b000) $display("FAIL async_abort: got %b required 000", {burst_valid, busy, ar_ready}); else n_pass++;
    @(negedge clk); rst_n = 1; burst_ready = 1;
    axi_read(12'h030, d, rs, lat);
    n_total++; if (d !== 64'd0) $display("FAIL done_cleared: got %h required 0", d); else n_pass++;
    axi_read(12'h000, d, rs, lat);
    n_total++; if (d !== 64'd0) $display("FAIL src_cleared: got %h required 0", d); else n_pass++;
    axi_read(12'h028, d, rs, lat);
    n_total++; if ({d, lat} !== {64'd1, 32'd0}) $display("FAIL id_restart: got %h lat %0d required 1 lat 0", d, lat); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rw_regs();
    test_launch_stall();
    test_completion();
    test_strb_order();
    test_errors();
    test_zero_len();
    test_reset_mid_launch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma_reg_frontend.md
Name: dma_reg_frontend

Overview:
- Configuration frontend of the SoC DMA engine, directly behind the crossbar's DMA slave port (base 0x5000_0000, 4 KiB window); the AXI-to-AXI-Lite conversion happens upstream.
- Holds the source, destination, length and config registers.
- A read of NEXT_ID launches one 1D transfer descriptor to the DMA backend, which drives the DMA master port, and returns the assigned ID.
- Counts backend completions so software can poll DONE.

Parameters:
- AddrWidth, 64, width of src/dst address registers.
- DataWidth, 64, AXI-Lite data width; fixed at 64.
- RegAddrWidth, 12, register offset width (4 KiB window).
- IdCntWidth, 32, width of transfer ID and completion counters.

Ports:
- clk_i in 1: clock.
- rst_ni in 1: asynchronous active-low reset.
- aw_valid_i in 1 / aw_ready_o out 1 / aw_addr_i in RegAddrWidth: AXI-Lite write address.
- w_valid_i in 1 / w_ready_o out 1 / w_data_i in 64 / w_strb_i in 8: write data.
- b_valid_o out 1 / b_ready_i in 1 / b_resp_o out 2: write response.
- ar_valid_i in 1 / ar_ready_o out 1 / ar_addr_i in RegAddrWidth: read address.
- r_valid_o out 1 / r_ready_i in 1 / r_data_o out 64 / r_resp_o out 2: read data.
- burst_valid_o out 1 / burst_ready_i in 1: descriptor handshake to backend.
- burst_src_o out AddrWidth / burst_dst_o out AddrWidth / burst_num_bytes_o out AddrWidth: descriptor fields.
- burst_decouple_o, burst_deburst_o, burst_serialize_o out 1 each: descriptor flags.
- burst_id_o out IdCntWidth: ID of the launched transfer.
- done_i in 1: single-cycle pulse, one per accepted descriptor, in order.
- busy_o out 1: transfers outstanding.

Behaviour:
- Register map, 64-bit, 8-byte aligned offsets:
  - 0x00 SRC RW.
  - 0x08 DST RW.
  - 0x10 NUM_BYTES RW.
  - 0x18 CONF RW: bit0 decouple, bit1 deburst, bit2 serialize; other bits read 0.
  - 0x20 STATUS RO: bit0 = busy_o.
  - 0x28 NEXT_ID RO, read launches a transfer.
  - 0x30 DONE RO: zero-extended completed count.
- Reset values: all registers 0; issued_q = 0, done_q = 0; all valid/ready outputs 0; resp 0; busy_o 0.
- Write FSM:
  - States: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted independently, in either order or the same cycle; at most one of each is held.
  - The register update happens in the cycle both are present. Byte-enable granular writes via w_strb_i.
  - b_valid_o rises the next cycle and holds until b_ready_i. aw_ready_o and w_ready_o stay low in W_RESP.
- Read FSM:
  - States: R_IDLE, R_LAUNCH, R_RESP.
  - In R_IDLE, ar_ready_o = 1. An accepted AR to any offset other than NEXT_ID goes to R_RESP, with data registered from that cycle.
  - An AR to NEXT_ID snapshots SRC/DST/NUM_BYTES/CONF, computes id = issued_q+1 (wraps mod 2^IdCntWidth) and goes to R_LAUNCH.
  - R_LAUNCH:
    - burst_valid_o = 1 with stable fields until burst_ready_i.
    - On handshake, issued_q <= id, r_data_o = id (zero-extended), go to R_RESP.
    - The read response therefore stalls while the backend is not ready. Writes arriving meanwhile update registers but do not alter the pending descriptor.
  - NUM_BYTES == 0: no burst is issued. issued_q and done_q both increment, and the read returns the id with 1-cycle latency.
  - R_RESP: r_valid_o held until r_ready_i, then back to R_IDLE.
- Errors, r/b_resp = 2'b10 (SLVERR), no side effect, read data 0:
  - misaligned address (addr[2:0] != 0);
  - offset > 0x30;
  - write to STATUS, NEXT_ID or DONE.
- OKAY = 2'b00.
- Completion accounting:
  - done_q increments on each done_i pulse, wrapping.
  - A done_i coincident with a zero-length launch increments done_q by 2.
- busy_o = (issued_q != done_q) | burst_valid_o, combinational from registered state.
- The read and write FSMs are independent. A same-cycle write to a register and read of it returns the old value.
- Asynchronous reset mid-transfer aborts every FSM to idle and clears counters. Any pending descriptor is dropped, and burst_valid_o falls immediately.

Decomposition:
- dma_reg_frontend_pkg:
  - register offset localparams;
  - CONF bit indices;
  - resp codes (RESP_OKAY, RESP_SLVERR);
  - a packed burst_req_t struct (src, dst, num_bytes, decouple, deburst, serialize, id);
  - FSM state enums.
- One natural sub-module, dma_reg_frontend_wr_join: captures AW and W independently and presents the joined address/data/strb with a valid flag to the register file.

Test Plan:
- Write SRC=0x8000_1000, DST=0x8000_2000, NUM_BYTES=0x40, CONF=0x5, then read all four -> values read back exactly, CONF=0x5, all OKAY.
- Read NEXT_ID with burst_ready_i held low 10 cycles then high -> burst_valid_o high 11 cycles with fields stable; r_valid_o 1 cycle after handshake; r_data=1.
- Two launches, then a single done_i pulse -> DONE reads 1, STATUS reads 1; after a second done_i, DONE=2, STATUS=0, busy_o=0.
- W arrives 3 cycles before AW to SRC, with w_strb=0x0F and data 0xFFFF_FFFF_FFFF_FFFF over SRC=0 -> SRC reads 0x0000_0000_FFFF_FFFF.
- Accesses to 0x04, 0x38 and a write to 0x28 -> SLVERR; no register change; issued_q unchanged.
- NUM_BYTES=0 launch -> no burst_valid_o; read returns id; DONE increments; busy_o stays 0. Separately, assert rst_ni during R_LAUNCH -> burst_valid_o falls immediately, counters read 0.
